imemory_stage: RTL and testbench

- Memory-access stage of the 16-bit pipelined core; sits between execute and the writeback mux.
- Performs data-memory loads and stores over a request/acknowledge interface to a variable-latency data memory.
- Stalls upstream while an access is outstanding.
- Registers all results into the MEM/WB pipeline register that feeds writeback. That register carries alu_data, mem_data, nextPc and the 3-bit writeback select.

---
 rtl/imemory_stage_pkg.sv | 25 ++
 rtl/imemory_stage_mem_wb_reg.sv | 55 +++++
 rtl/imemory_stage.sv | 203 ++++++++++++++++++++
 tb/tb_imemory_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/imemory_stage_pkg.sv
// imemory_stage_pkg
//   Shared definitions for the memory-access stage of the 16-bit pipelined core:
//   data width, writeback-select encodings, FSM state encoding and a small
//   address-alignment helper.
package imemory_stage_pkg;

  localparam int DATA_W = 16;

  // Writeback select encodings (carried through the stage unchanged)
  localparam logic [2:0] SEL_MEM  = 3'b000;
  localparam logic [2:0] SEL_ALU  = 3'b001;
  localparam logic [2:0] SEL_PC   = 3'b010;
  localparam logic [2:0] SEL_ZERO = 3'b011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // A halfword access is misaligned when the byte-address LSB is set
  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/imemory_stage_mem_wb_reg.sv
// mem_wb_reg
//   MEM/WB pipeline register feeding writeback. Data fields load only when
//   load_en is high; q_valid follows load_en every cycle so a non-loading
//   cycle presents a bubble. q_regwrite is cleared on bubbles so the
//   register-file write enable is always qualified by q_valid.
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   load_en         capture d_* this cycle
//   d_*             next-state payload
//   q_*             registered payload to writeback
module mem_wb_reg
  import imemory_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [DATA_W-1:0] d_alu_data,
  input  logic [DATA_W-1:0] d_mem_data,
  input  logic [DATA_W-1:0] d_nextPc,
  input  logic [2:0]        d_Sel_WBreg,
  input  logic [2:0]        d_wb_reg,
  input  logic              d_regwrite,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_alu_data,
  output logic [DATA_W-1:0] q_mem_data,
  output logic [DATA_W-1:0] q_nextPc,
  output logic [2:0]        q_Sel_WBreg,
  output logic [2:0]        q_wb_reg,
  output logic              q_regwrite
);

  // Pipeline register: valid/regwrite every cycle, payload on load_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid     <= 1'b0;
      q_alu_data  <= '0;
      q_mem_data  <= '0;
      q_nextPc    <= '0;
      q_Sel_WBreg <= 3'b000;
      q_wb_reg    <= 3'b000;
      q_regwrite  <= 1'b0;
    end else begin
      q_valid    <= load_en;
      q_regwrite <= load_en ? d_regwrite : 1'b0;
      if (load_en) begin
        q_alu_data  <= d_alu_data;
        q_mem_data  <= d_mem_data;
        q_nextPc    <= d_nextPc;
        q_Sel_WBreg <= d_Sel_WBreg;
        q_wb_reg    <= d_wb_reg;
      end
    end
  end

endmodule

// File: rtl/imemory_stage.sv
// imemory_stage
//   Memory-access stage: sits between execute and the writeback mux. Non-memory
//   instructions pass to the MEM/WB register in one cycle. Loads/stores latch
//   their fields, issue a request to a variable-latency data memory and stall
//   upstream until mem_ack or a timeout. Misaligned accesses (ALIGN_CHECK=1)
//   and timeouts drop the instruction and set the sticky err flag.
// Ports:
//   clk, rst                 clock / asynchronous active-high reset
//   in_*                     instruction from execute
//   stall_out                upstream hold (asserted for every REQ cycle)
//   mem_req/we/addr/wdata    data-memory request (stable throughout REQ)
//   mem_ack, mem_rdata       data-memory completion
//   wb_*                     MEM/WB register outputs
//   err                      sticky timeout / misalignment flag
module imemory_stage
  import imemory_stage_pkg::*;
#(
  parameter int TIMEOUT     = 16,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_en,
  input  logic              in_mem_wr,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [DATA_W-1:0] in_wr_data,
  input  logic [DATA_W-1:0] in_nextPc,
  input  logic [2:0]        in_Sel_WBreg,
  input  logic [2:0]        in_wb_reg,
  input  logic              in_regwrite,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_alu_data,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_nextPc,
  output logic [2:0]        wb_Sel_WBreg,
  output logic [2:0]        wb_wb_reg,
  output logic              wb_regwrite,
  output logic              err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t            state_r;
  logic [7:0]        cnt_r;
  logic              req_r;
  logic              stall_r;
  logic              err_r;
  logic              lat_we_r;
  logic [DATA_W-1:0] lat_addr_r;
  logic [DATA_W-1:0] lat_wdata_r;
  logic [DATA_W-1:0] lat_nextPc_r;
  logic [2:0]        lat_sel_r;
  logic [2:0]        lat_wb_reg_r;
  logic              lat_regwrite_r;

  logic              mem_op_s;
  logic              reject_s;

  logic              wb_load_s;
  logic [DATA_W-1:0] wb_alu_s;
  logic [DATA_W-1:0] wb_mem_s;
  logic [DATA_W-1:0] wb_pc_s;
  logic [2:0]        wb_sel_s;
  logic [2:0]        wb_reg_s;
  logic              wb_rw_s;

  assign mem_op_s = in_valid && in_mem_en;
  assign reject_s = (ALIGN_CHECK != 0) && is_misaligned(in_alu_data);

  // Access FSM: state, timeout counter, latched request fields, sticky err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 8'd0;
      req_r          <= 1'b0;
      stall_r        <= 1'b0;
      err_r          <= 1'b0;
      lat_we_r       <= 1'b0;
      lat_addr_r     <= '0;
      lat_wdata_r    <= '0;
      lat_nextPc_r   <= '0;
      lat_sel_r      <= 3'b000;
      lat_wb_reg_r   <= 3'b000;
      lat_regwrite_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_op_s) begin
            if (reject_s) begin
              err_r <= 1'b1;
            end else begin
              lat_we_r       <= in_mem_wr;
              lat_addr_r     <= in_alu_data;
              lat_wdata_r    <= in_wr_data;
              lat_nextPc_r   <= in_nextPc;
              lat_sel_r      <= in_Sel_WBreg;
              lat_wb_reg_r   <= in_wb_reg;
              lat_regwrite_r <= in_regwrite;
              cnt_r          <= 8'd0;
              req_r          <= 1'b1;
              stall_r        <= 1'b1;
              state_r        <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            req_r   <= 1'b0;
            stall_r <= 1'b0;
            state_r <= ST_IDLE;
          end else if (cnt_r == TIMEOUT_LAST) begin
            // Memory never answered: abandon the access
            err_r   <= 1'b1;
            req_r   <= 1'b0;
            stall_r <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          req_r   <= 1'b0;
          stall_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Select what the MEM/WB register captures this cycle
  always_comb begin
    wb_load_s = 1'b0;
    wb_alu_s  = lat_addr_r;
    wb_mem_s  = '0;
    wb_pc_s   = lat_nextPc_r;
    wb_sel_s  = lat_sel_r;
    wb_reg_s  = lat_wb_reg_r;
    wb_rw_s   = lat_regwrite_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && !in_mem_en) begin
          wb_load_s = 1'b1;
          wb_alu_s  = in_alu_data;
          wb_mem_s  = '0;
          wb_pc_s   = in_nextPc;
          wb_sel_s  = in_Sel_WBreg;
          wb_reg_s  = in_wb_reg;
          wb_rw_s   = in_regwrite;
        end else begin
          wb_load_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          wb_load_s = 1'b1;
          // Stores return no data and never write the register file
          wb_mem_s  = lat_we_r ? '0 : mem_rdata;
          wb_rw_s   = lat_we_r ? 1'b0 : lat_regwrite_r;
        end else begin
          wb_load_s = 1'b0;
        end
      end
      default: begin
        wb_load_s = 1'b0;
      end
    endcase
  end

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .rst         (rst),
    .load_en     (wb_load_s),
    .d_alu_data  (wb_alu_s),
    .d_mem_data  (wb_mem_s),
    .d_nextPc    (wb_pc_s),
    .d_Sel_WBreg (wb_sel_s),
    .d_wb_reg    (wb_reg_s),
    .d_regwrite  (wb_rw_s),
    .q_valid     (wb_valid),
    .q_alu_data  (wb_alu_data),
    .q_mem_data  (wb_mem_data),
    .q_nextPc    (wb_nextPc),
    .q_Sel_WBreg (wb_Sel_WBreg),
    .q_wb_reg    (wb_wb_reg),
    .q_regwrite  (wb_regwrite)
  );

  assign stall_out = stall_r;
  assign mem_req   = req_r;
  assign mem_we    = lat_we_r;
  assign mem_addr  = lat_addr_r;
  assign mem_wdata = lat_wdata_r;
  assign err       = err_r;

endmodule

// File: tb/tb_imemory_stage.sv
// tb_imemory_stage
//   Directed bench for imemory_stage (TIMEOUT=4, ALIGN_CHECK=1). Inputs change
//   1 time unit after the rising edge; outputs are checked at the same point.
module tb_imemory_stage;
  import imemory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_mem_en = 1'b0;
  logic        in_mem_wr = 1'b0;
  logic [15:0] in_alu_data = 16'h0000;
  logic [15:0] in_wr_data = 16'h0000;
  logic [15:0] in_nextPc = 16'h0000;
  logic [2:0]  in_Sel_WBreg = 3'b000;
  logic [2:0]  in_wb_reg = 3'b000;
  logic        in_regwrite = 1'b0;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        wb_valid;
  logic [15:0] wb_alu_data;
  logic [15:0] wb_mem_data;
  logic [15:0] wb_nextPc;
  logic [2:0]  wb_Sel_WBreg;
  logic [2:0]  wb_wb_reg;
  logic        wb_regwrite;
  logic        err;

  int total = 0;
  int bad   = 0;
  int n;

  imemory_stage #(.TIMEOUT(4), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_mem_en(in_mem_en), .in_mem_wr(in_mem_wr),
    .in_alu_data(in_alu_data), .in_wr_data(in_wr_data), .in_nextPc(in_nextPc),
    .in_Sel_WBreg(in_Sel_WBreg), .in_wb_reg(in_wb_reg), .in_regwrite(in_regwrite),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_alu_data(wb_alu_data), .wb_mem_data(wb_mem_data),
    .wb_nextPc(wb_nextPc), .wb_Sel_WBreg(wb_Sel_WBreg), .wb_wb_reg(wb_wb_reg),
    .wb_regwrite(wb_regwrite), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_mem_en = 1'b0; in_mem_wr = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_stall", {15'd0, stall_out}, 16'd0);
    chk("rst_wbv", {15'd0, wb_valid}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wbalu", wb_alu_data, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    // ALU op: one-cycle pass-through
    in_valid = 1'b1; in_mem_en = 1'b0; in_alu_data = 16'h1234;
    in_Sel_WBreg = SEL_ALU; in_wb_reg = 3'd3; in_regwrite = 1'b1; in_nextPc = 16'h0102;
    chk("alu_stall_pre", {15'd0, stall_out}, 16'd0);
    tick();
    idle_inputs();
    chk("alu_wbv", {15'd0, wb_valid}, 16'd1);
    chk("alu_data", wb_alu_data, 16'h1234);
    chk("alu_reg", {13'd0, wb_wb_reg}, 16'd3);
    chk("alu_sel", {13'd0, wb_Sel_WBreg}, 16'd1);
    chk("alu_mem", wb_mem_data, 16'h0000);
    chk("alu_pc", wb_nextPc, 16'h0102);
    chk("alu_rw", {15'd0, wb_regwrite}, 16'd1);
    chk("alu_stall", {15'd0, stall_out}, 16'd0);
    tick();
    chk("bubble_wbv", {15'd0, wb_valid}, 16'd0);
    chk("bubble_rw", {15'd0, wb_regwrite}, 16'd0);

    // mem_ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    chk("idleack_wbv", {15'd0, wb_valid}, 16'd0);
    chk("idleack_req", {15'd0, mem_req}, 16'd0);

    // Load at 0x0040, ack in 3rd REQ cycle
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_wr = 1'b0; in_alu_data = 16'h0040;
    in_Sel_WBreg = SEL_MEM; in_wb_reg = 3'd5; in_regwrite = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("ld_req", {15'd0, mem_req}, 16'd1);
      chk("ld_stall", {15'd0, stall_out}, 16'd1);
      chk("ld_addr", mem_addr, 16'h0040);
      chk("ld_we", {15'd0, mem_we}, 16'd0);
      chk("ld_wbv_stalled", {15'd0, wb_valid}, 16'd0);
      if (i == 2) begin
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("ld_wbv", {15'd0, wb_valid}, 16'd1);
    chk("ld_data", wb_mem_data, 16'hBEEF);
    chk("ld_reg", {13'd0, wb_wb_reg}, 16'd5);
    chk("ld_rw", {15'd0, wb_regwrite}, 16'd1);
    chk("ld_req_done", {15'd0, mem_req}, 16'd0);
    chk("ld_stall_done", {15'd0, stall_out}, 16'd0);

    // Store 0xA5A5 at 0x0010, ack in first REQ cycle
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_wr = 1'b1; in_alu_data = 16'h0010;
    in_wr_data = 16'hA5A5; in_regwrite = 1'b1; in_wb_reg = 3'd2;
    tick();
    idle_inputs();
    chk("st_req", {15'd0, mem_req}, 16'd1);
    chk("st_we", {15'd0, mem_we}, 16'd1);
    chk("st_wdata", mem_wdata, 16'hA5A5);
    chk("st_addr", mem_addr, 16'h0010);
    chk("st_wbv_early", {15'd0, wb_valid}, 16'd0);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    chk("st_wbv", {15'd0, wb_valid}, 16'd1);
    chk("st_rw", {15'd0, wb_regwrite}, 16'd0);
    chk("st_mem", wb_mem_data, 16'h0000);
    chk("st_alu", wb_alu_data, 16'h0010);

    // Misaligned load: dropped, err set
    chk("mis_err_pre", {15'd0, err}, 16'd0);
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_wr = 1'b0; in_alu_data = 16'h0021;
    tick();
    idle_inputs();
    chk("mis_req", {15'd0, mem_req}, 16'd0);
    chk("mis_err", {15'd0, err}, 16'd1);
    chk("mis_wbv", {15'd0, wb_valid}, 16'd0);
    chk("mis_stall", {15'd0, stall_out}, 16'd0);
    in_valid = 1'b1; in_mem_en = 1'b0; in_alu_data = 16'h5A5A; in_wb_reg = 3'd1;
    tick();
    idle_inputs();
    chk("mis_next_wbv", {15'd0, wb_valid}, 16'd1);
    chk("mis_next_alu", wb_alu_data, 16'h5A5A);
    chk("mis_err_sticky", {15'd0, err}, 16'd1);

    // Reset clears err
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk("rst_err_clr", {15'd0, err}, 16'd0);
    tick();

    // Load with no ack: abandoned after TIMEOUT=4 REQ cycles
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_wr = 1'b0; in_alu_data = 16'h0050;
    tick();
    idle_inputs();
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      chk("to_wbv_stalled", {15'd0, wb_valid}, 16'd0);
      n++;
      tick();
    end
    chk("to_req_cycles", 16'(n), 16'd4);
    chk("to_err", {15'd0, err}, 16'd1);
    chk("to_wbv", {15'd0, wb_valid}, 16'd0);
    chk("to_stall", {15'd0, stall_out}, 16'd0);
    tick();
    chk("to_err_sticky", {15'd0, err}, 16'd1);
    chk("to_req_idle", {15'd0, mem_req}, 16'd0);

    // Asynchronous reset in the second REQ cycle
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_wr = 1'b0; in_alu_data = 16'h0060;
    tick();
    idle_inputs();
    tick();
    chk("ar_req_before", {15'd0, mem_req}, 16'd1);
    rst = 1'b1;
    #1;
    chk("ar_req", {15'd0, mem_req}, 16'd0);
    chk("ar_stall", {15'd0, stall_out}, 16'd0);
    chk("ar_wbv", {15'd0, wb_valid}, 16'd0);
    chk("ar_addr", mem_addr, 16'h0000);
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_mem_en = 1'b0; in_alu_data = 16'hC0DE; in_wb_reg = 3'd7;
    tick();
    idle_inputs();
    chk("ar_alu_wbv", {15'd0, wb_valid}, 16'd1);
    chk("ar_alu_data", wb_alu_data, 16'hC0DE);
    chk("ar_alu_reg", {13'd0, wb_wb_reg}, 16'd7);
    chk("ar_alu_req", {15'd0, mem_req}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
